// File: rtl/led_fade_sink.sv
// LED fade sink: takes 16-bit words and fades four LEDs toward their nibble targets.
// Optional build macro LED_FADE_GAMMA_EN switches the PWM compare to a squared (perceptual) level.
module led_fade_sink #(
    parameter int STEP_DIV   = 100000,
    parameter int HOLD_STEPS = 500
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] rand_data,
    input  logic        rand_valid,
    output logic        rand_ready,
    output logic [3:0]  leds,
    output logic [1:0]  o_dbg_state,
    output logic [31:0] o_dbg_levels
);
    localparam int SW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam int HW = (HOLD_STEPS > 1) ? $clog2(HOLD_STEPS) : 1;
    localparam logic [SW-1:0] STEP_LAST = SW'(STEP_DIV - 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_STEPS - 1);

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_FADE = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    state_t        r_state;
    logic          r_ready;
    logic [3:0]    r_leds;
    logic [7:0]    r_level  [4];
    logic [7:0]    r_target [4];
    logic [7:0]    r_pwm_cnt;
    logic [SW-1:0] r_step_cnt;
    logic [HW-1:0] r_hold_cnt;

    logic          w_step_tick;
    logic          w_xfer;
    logic          w_all_done;
    logic [7:0]    w_level_nxt [4];
    logic [7:0]    w_cmp       [4];

    // Handshake: a word transfers on any cycle where rand_valid and rand_ready are both
    // high; ready is registered, held high in REQ until that transfer, and low elsewhere.
    assign w_xfer      = rand_valid && r_ready;
    assign w_step_tick = (r_step_cnt == STEP_LAST);

    always_comb begin
        w_all_done = 1'b1;
        for (int i = 0; i < 4; i++) begin
            w_level_nxt[i] = r_level[i];
            if (r_level[i] < r_target[i]) begin
                w_level_nxt[i] = r_level[i] + 8'd1;
            end else if (r_level[i] > r_target[i]) begin
                w_level_nxt[i] = r_level[i] - 8'd1;
            end
            if (w_level_nxt[i] != r_target[i]) begin
                w_all_done = 1'b0;
            end
        end
    end

`ifdef LED_FADE_GAMMA_EN
    logic [15:0] w_sq [4];

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            w_sq[i]  = r_level[i] * r_level[i];
            w_cmp[i] = w_sq[i][15:8];
        end
    end
`else
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            w_cmp[i] = r_level[i];
        end
    end
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pwm_cnt  <= 8'd0;
            r_step_cnt <= '0;
            r_leds     <= 4'b0000;
        end else begin
            r_pwm_cnt  <= r_pwm_cnt + 8'd1;
            r_step_cnt <= w_step_tick ? '0 : r_step_cnt + 1'b1;
            for (int i = 0; i < 4; i++) begin
                r_leds[i] <= (w_cmp[i] > r_pwm_cnt);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= S_REQ;
            r_ready    <= 1'b0;
            r_hold_cnt <= '0;
            for (int i = 0; i < 4; i++) begin
                r_level[i]  <= 8'h00;
                r_target[i] <= 8'h00;
            end
        end else begin
            case (r_state)
                S_REQ: begin
                    if (w_xfer) begin
                        for (int i = 0; i < 4; i++) begin
                            r_target[i] <= {rand_data[4*i +: 4], rand_data[4*i +: 4]};
                        end
                        r_ready <= 1'b0;
                        r_state <= S_FADE;
                    end else begin
                        r_ready <= 1'b1;
                    end
                end
                S_FADE: begin
                    r_ready <= 1'b0;
                    if (w_step_tick) begin
                        for (int i = 0; i < 4; i++) begin
                            r_level[i] <= w_level_nxt[i];
                        end
                        if (w_all_done) begin
                            r_hold_cnt <= '0;
                            r_state    <= S_HOLD;
                        end
                    end
                end
                S_HOLD: begin
                    if (w_step_tick) begin
                        if (r_hold_cnt == HOLD_LAST) begin
                            r_ready <= 1'b1;
                            r_state <= S_REQ;
                        end else begin
                            r_ready    <= 1'b0;
                            r_hold_cnt <= r_hold_cnt + 1'b1;
                        end
                    end else begin
                        r_ready <= 1'b0;
                    end
                end
                default: begin
                    r_ready <= 1'b0;
                    r_state <= S_REQ;
                end
            endcase
        end
    end

    assign rand_ready   = r_ready;
    assign leds         = r_leds;
    assign o_dbg_state  = r_state;
    assign o_dbg_levels = {r_level[3], r_level[2], r_level[1], r_level[0]};

endmodule

// File: tb/tb_led_fade_sink.sv
// Bench for led_fade_sink: cycle model compared every cycle plus directed literal checks.
// Honours LED_FADE_GAMMA_EN for the perceptual duty expectations.
module tb_led_fade_sink;
    localparam int STEP_DIV   = 4;
    localparam int HOLD_STEPS = 2;
    localparam logic [1:0] ST_REQ  = 2'd0;
    localparam logic [1:0] ST_FADE = 2'd1;
    localparam logic [1:0] ST_HOLD = 2'd2;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] rand_data = 16'h0000;
    logic        rand_valid = 1'b0;
    logic        rand_ready;
    logic [3:0]  leds;
    logic [1:0]  o_dbg_state;
    logic [31:0] o_dbg_levels;

    int n_checks = 0;
    int n_fail   = 0;
    int duty [4];

    led_fade_sink #(.STEP_DIV(STEP_DIV), .HOLD_STEPS(HOLD_STEPS)) dut (
        .clk         (clk),
        .rst         (rst),
        .rand_data   (rand_data),
        .rand_valid  (rand_valid),
        .rand_ready  (rand_ready),
        .leds        (leds),
        .o_dbg_state (o_dbg_state),
        .o_dbg_levels(o_dbg_levels)
    );

    // clock / reset
    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=0x%0h required=0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // behavioural model: counts edges since reset release, fades by plain arithmetic
    int         m_n;
    logic [1:0] m_phase;
    logic       m_ready;
    logic [3:0] m_leds;
    int         m_hold;
    int         m_lvl [4];
    int         m_tgt [4];
    logic       m_tick;
    logic       m_done;
    logic [31:0] m_lvl_p;

    function automatic int perc(input int l);
`ifdef LED_FADE_GAMMA_EN
        return (l * l) / 256;
`else
        return l;
`endif
    endfunction

    function automatic int toward(input int l, input int t);
        if (l < t) return l + 1;
        if (l > t) return l - 1;
        return l;
    endfunction

    always_comb begin
        m_tick = ((m_n % STEP_DIV) == STEP_DIV - 1);
        m_done = 1'b1;
        m_lvl_p = '0;
        for (int i = 0; i < 4; i++) begin
            if (m_lvl[i] - m_tgt[i] > 1 || m_tgt[i] - m_lvl[i] > 1) m_done = 1'b0;
            m_lvl_p[8*i +: 8] = m_lvl[i][7:0];
        end
    end

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_n     <= 0;
            m_phase <= ST_REQ;
            m_ready <= 1'b0;
            m_leds  <= 4'b0000;
            m_hold  <= 0;
            for (int i = 0; i < 4; i++) begin
                m_lvl[i] <= 0;
                m_tgt[i] <= 0;
            end
        end else begin
            for (int i = 0; i < 4; i++) m_leds[i] <= (perc(m_lvl[i]) > (m_n % 256));
            m_n <= m_n + 1;
            case (m_phase)
                ST_REQ: begin
                    if (rand_valid && m_ready) begin
                        for (int i = 0; i < 4; i++) m_tgt[i] <= 17 * int'(rand_data[4*i +: 4]);
                        m_ready <= 1'b0;
                        m_phase <= ST_FADE;
                    end else begin
                        m_ready <= 1'b1;
                    end
                end
                ST_FADE: begin
                    if (m_tick) begin
                        for (int i = 0; i < 4; i++) m_lvl[i] <= toward(m_lvl[i], m_tgt[i]);
                        if (m_done) begin
                            m_phase <= ST_HOLD;
                            m_hold  <= 0;
                        end
                    end
                end
                default: begin
                    if (m_tick) begin
                        if (m_hold == HOLD_STEPS - 1) begin
                            m_phase <= ST_REQ;
                            m_ready <= 1'b1;
                        end else begin
                            m_hold <= m_hold + 1;
                        end
                    end
                end
            endcase
        end
    end

    // per-cycle compare against the model
    always @(negedge clk) begin
        check("cyc_leds", {28'd0, leds}, {28'd0, m_leds});
        check("cyc_ready", {31'd0, rand_ready}, {31'd0, m_ready});
        check("cyc_state", {30'd0, o_dbg_state}, {30'd0, m_phase});
        check("cyc_levels", o_dbg_levels, m_lvl_p);
    end

    // driver tasks
    task automatic wait_state(input logic [1:0] s, input int max_cyc, input string nm);
        bit hit;
        hit = 1'b0;
        for (int k = 0; k < max_cyc && !hit; k++) begin
            @(negedge clk);
            if (o_dbg_state == s) hit = 1'b1;
        end
        check(nm, {31'd0, hit}, 32'd1);
    endtask

    task automatic send_word(input logic [15:0] w);
        rand_data  = w;
        rand_valid = 1'b1;
        @(negedge clk);
        check("xfer_ready_low", {31'd0, rand_ready}, 32'd0);
        check("xfer_state_fade", {30'd0, o_dbg_state}, {30'd0, ST_FADE});
        rand_valid = 1'b0;
    endtask

    task automatic measure_duty();
        for (int i = 0; i < 4; i++) duty[i] = 0;
        for (int k = 0; k < 256; k++) begin
            @(negedge clk);
            rand_data = rand_data ^ 16'hFFFF;
            for (int i = 0; i < 4; i++) duty[i] += int'(leds[i]);
        end
        check("req_ready_held", {31'd0, rand_ready}, 32'd1);
        check("req_state_held", {30'd0, o_dbg_state}, {30'd0, ST_REQ});
    endtask

    task automatic check_duty(input int e0, input int e1, input int e2, input int e3);
        check("duty0", duty[0], e0);
        check("duty1", duty[1], e1);
        check("duty2", duty[2], e2);
        check("duty3", duty[3], e3);
    endtask

    initial begin
        bit hit;
        rst        = 1'b0;
        rand_valid = 1'b1;
        rand_data  = 16'h000F;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check("rst_leds", {28'd0, leds}, 32'd0);
            check("rst_ready", {31'd0, rand_ready}, 32'd0);
        end
        rst = 1'b1;
        @(negedge clk);
        check("rel_ready_first_edge", {31'd0, rand_ready}, 32'd1);
        check("rel_state_req", {30'd0, o_dbg_state}, {30'd0, ST_REQ});
        @(negedge clk);
        check("rel_xfer_ready", {31'd0, rand_ready}, 32'd0);
        check("rel_xfer_fade", {30'd0, o_dbg_state}, {30'd0, ST_FADE});
        rand_valid = 1'b0;

        // fade up 000F: 255 ticks, ticks every 4th edge starting at edge index 3
        wait_state(ST_HOLD, 1100, "fadeup_reach_hold");
        check("fadeup_hold_edge", m_n, 1020);
        check("fadeup_levels", o_dbg_levels, 32'h000000FF);
        wait_state(ST_REQ, 20, "fadeup_back_req");
        check("fadeup_req_edge", m_n, 1028);
        check("fadeup_req_ready", {31'd0, rand_ready}, 32'd1);
        measure_duty();
`ifdef LED_FADE_GAMMA_EN
        check_duty(254, 0, 0, 0);
`else
        check_duty(255, 0, 0, 0);
`endif

        // mixed 50A0 from FF/00/00/00
        send_word(16'h50A0);
        wait_state(ST_HOLD, 1100, "mixed_reach_hold");
        check("mixed_levels", o_dbg_levels, 32'h5500AA00);
        wait_state(ST_REQ, 20, "mixed_back_req");
        measure_duty();
`ifdef LED_FADE_GAMMA_EN
        check_duty(0, 112, 0, 28);
`else
        check_duty(0, 170, 0, 85);
`endif

        send_word(16'h8888);
        wait_state(ST_HOLD, 1100, "mid_reach_hold");
        check("mid_levels", o_dbg_levels, 32'h88888888);
        wait_state(ST_REQ, 20, "mid_back_req");
        measure_duty();
`ifdef LED_FADE_GAMMA_EN
        check_duty(72, 72, 72, 72);
`else
        check_duty(136, 136, 136, 136);
`endif

        // word equal to current levels still passes through FADE
        send_word(16'h8888);
        wait_state(ST_HOLD, 6, "same_reach_hold");
        check("same_levels", o_dbg_levels, 32'h88888888);
        wait_state(ST_REQ, 20, "same_back_req");

        // reset mid-fade at level0 = 0x37
        send_word(16'hFFF0);
        hit = 1'b0;
        for (int k = 0; k < 600 && !hit; k++) begin
            @(negedge clk);
            if (o_dbg_levels[7:0] == 8'h37) hit = 1'b1;
        end
        check("midfade_level37_seen", {31'd0, hit}, 32'd1);
        #2 rst = 1'b0;
        #1;
        check("async_leds", {28'd0, leds}, 32'd0);
        check("async_ready", {31'd0, rand_ready}, 32'd0);
        check("async_state", {30'd0, o_dbg_state}, {30'd0, ST_REQ});
        check("async_levels", o_dbg_levels, 32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("rerel_ready", {31'd0, rand_ready}, 32'd1);
        check("rerel_levels", o_dbg_levels, 32'd0);
        repeat (4) @(negedge clk);

        // final report
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/led_fade_sink.md
Name: led_fade_sink

Overview:
- Downstream consumer of the board's random-value source; takes 16-bit random words over a valid/ready handshake.
- Drives 4 PMOD LEDs: each nibble of a word is one LED's brightness target.
- LEDs fade linearly toward their targets using 8-bit PWM, hold, then request the next word.
- Sits between the random generator and the PMOD[55:52] LED pins in the chip top.

Parameters:
- STEP_DIV, 100000, clk cycles per fade step (1 kHz at 100 MHz); minimum 2.
- HOLD_STEPS, 500, fade steps to hold once all LEDs reach their targets; minimum 1.

Ports:
- clk  input  1  100 MHz system clock.
- rst  input  1  Reset. Asynchronous and active-low: low resets, high runs.
- rand_data  input  16  Random word. Nibble i (bits 4i+3:4i) is the target for LED i.
- rand_valid  input  1  Source has a word on rand_data.
- rand_ready  output  1  Sink accepts a word this cycle.
- leds  output  4  PWM LED drive; bit i is LED i; active-high.

Behaviour:
- Reset (rst low, asynchronous), all held until release:
  - state=REQ; rand_ready=0; leds=4'b0000.
  - levels[0..3]=8'h00; targets=8'h00; pwm_cnt=0; step_cnt=0; hold_cnt=0.
- First rising clk after rst goes high: rand_ready registers to 1.
- pwm_cnt: 8-bit free-running counter, +1 every clk, wraps 255->0.
- step_tick: 1-cycle pulse when step_cnt==STEP_DIV-1; step_cnt then returns to 0. step_cnt runs in every state.
- PWM output, registered, 1-cycle latency:
  - leds[i] <= (level[i] > pwm_cnt).
  - level 0x00 is always off; 0xFF is on 255 of every 256 cycles.
- Target mapping: target[i] = {nibble_i, nibble_i}, so 0x0->0x00, 0x5->0x55, 0xF->0xFF.
- States:
  - REQ:
    - rand_ready=1.
    - On rand_valid&&rand_ready: latch all 4 targets, rand_ready<=0, go to FADE.
    - rand_data is ignored whenever the handshake does not complete.
  - FADE:
    - rand_ready=0.
    - On each step_tick, each level moves 1 toward its target: +1 if below, -1 if above, unchanged if equal.
    - When all 4 levels equal their targets after an update: hold_cnt<=0, go to HOLD.
    - A word whose targets equal the current levels still passes through FADE: the check happens on the next step_tick, then HOLD.
  - HOLD:
    - rand_ready=0.
    - hold_cnt increments on each step_tick.
    - When hold_cnt==HOLD_STEPS-1 on a step_tick: go to REQ; rand_ready=1 from the next cycle.
- Handshake rules:
  - rand_ready never drops in REQ until a transfer completes.
  - rand_valid is allowed to arrive before rand_ready; the word transfers on the first cycle both are high.
  - Exactly one word transfers per REQ visit.
- Arithmetic: levels are 8-bit and saturate naturally, because steps stop at the target. No wrap is possible.
- Worst-case fade: 255 steps.
- Reset mid-FADE or mid-HOLD: everything returns to the reset values immediately; LEDs go dark asynchronously.

Optional Feature:
- Macro: LED_FADE_GAMMA_EN.
- Defined:
  - The PWM compare uses a perceptual level: g[i] = (level[i]*level[i])>>8, an 8x8 multiply keeping the upper 8 bits.
  - leds[i] <= (g[i] > pwm_cnt). Still registered, still 1-cycle latency.
  - level 0xFF gives g=0xFE.
- Not defined: linear compare as in Behaviour. No multiplier is instantiated.
- The FSM, handshake and fade timing are identical in both builds.

Test Plan (STEP_DIV=4, HOLD_STEPS=2 unless stated):
- Reset:
  - Stimulus: hold rst low 10 cycles with rand_valid=1.
  - Required: leds=0 and rand_ready=0 throughout.
  - After release: rand_ready=1 on the first edge; the word transfers on the next edge.
- Fade up:
  - Stimulus: send 16'h000F.
  - Required: level0 reaches 0xFF after 255 step_ticks (about 1020 clk). LEDs 1-3 stay 0.
  - Then HOLD for 2 step_ticks, then rand_ready=1.
- Fade down / mixed:
  - Stimulus: from all at 0xFF, send 16'h50A0.
  - Required: levels end at 0x00, 0xAA, 0x00, 0x55.
  - The slowest channel, 255 steps, gates HOLD entry.
- Handshake:
  - Stimulus: keep rand_valid low for 50 cycles in REQ with data toggling.
  - Required: no state change; rand_ready stays 1.
  - On valid, exactly one transfer occurs; rand_ready=0 on the following cycle.
- PWM duty:
  - Stimulus: STEP_DIV=2; hold level 0x80.
  - Required: leds[0] high for exactly 128 of 256 consecutive cycles.
  - With LED_FADE_GAMMA_EN: high for exactly 64 of 256 (g=0x40).
- Reset mid-FADE:
  - Stimulus: pull rst low while level0=0x37.
  - Required: leds=0 immediately (asynchronous). After release: levels=0 and state=REQ.
